// File: rtl/eth_tx_tstamp_matcher.sv
// rtl/eth_tx_tstamp_matcher.sv - pairs MAC egress timestamps with queued TX fingerprints
// Emits MATCH, MISSED or ORPHAN records; timestamps that cannot be paired are flagged, never mis-paired.
module eth_tx_tstamp_matcher #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TS_WIDTH       = 96,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           asi_fingerprint_valid,
  input  logic [7:0]                     asi_fingerprint,
  output logic                           asi_fingerprint_ready,
  input  logic                           tstamp_valid,
  input  logic [TS_WIDTH-1:0]            tstamp_data,
  input  logic [7:0]                     tstamp_fingerprint,
  output logic                           aso_tsrec_valid,
  input  logic                           aso_tsrec_ready,
  output logic [7:0]                     aso_tsrec_fingerprint,
  output logic [TS_WIDTH-1:0]            aso_tsrec_timestamp,
  output logic [1:0]                     aso_tsrec_status,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [CNT_WIDTH-1:0]           cnt_match,
  output logic [CNT_WIDTH-1:0]           cnt_miss,
  output logic [CNT_WIDTH-1:0]           cnt_orphan,
  output logic [CNT_WIDTH-1:0]           cnt_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] ST_MATCH  = 2'd0;
  localparam logic [1:0] ST_MISSED = 2'd1;
  localparam logic [1:0] ST_ORPHAN = 2'd2;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  state_t              state;
  logic                pend_valid;
  logic [TS_WIDTH-1:0] pend_ts;
  logic [7:0]          pend_fp;
  logic [TW-1:0]       tcnt;

  logic       fifo_empty, fifo_full, push, pop, idle;
  logic       do_match, do_miss_fp, do_orphan, do_timeout, pend_consume, load;
  logic [7:0] head;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr];
  assign push       = asi_fingerprint_valid & ~fifo_full;
  assign idle       = (state == S_IDLE);

  // Decision priority in IDLE: match, fingerprint mismatch, orphan, timeout
  assign do_match     = idle & pend_valid & ~fifo_empty & (head == pend_fp);
  assign do_miss_fp   = idle & pend_valid & ~fifo_empty & (head != pend_fp);
  assign do_orphan    = idle & pend_valid & fifo_empty;
  assign do_timeout   = idle & ~pend_valid & ~fifo_empty & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign pop          = do_match | do_miss_fp | do_timeout;
  assign pend_consume = do_match | do_orphan;
  assign load         = pop | do_orphan;

  assign asi_fingerprint_ready = ~fifo_full;
  assign fifo_level            = level;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= asi_fingerprint;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A mismatched pending timestamp stays loaded to be retried against the next head
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid   <= 1'b0;
      pend_ts      <= '0;
      pend_fp      <= '0;
      cnt_overflow <= '0;
    end else if (tstamp_valid) begin
      if (!pend_valid || pend_consume) begin
        pend_valid <= 1'b1;
        pend_ts    <= tstamp_data;
        pend_fp    <= tstamp_fingerprint;
      end else begin
        cnt_overflow <= sat_inc(cnt_overflow);
      end
    end else if (pend_consume) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (pop || fifo_empty || pend_valid) begin
      tcnt <= '0;
    end else if (idle) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= S_IDLE;
      aso_tsrec_valid       <= 1'b0;
      aso_tsrec_fingerprint <= '0;
      aso_tsrec_timestamp   <= '0;
      aso_tsrec_status      <= ST_MATCH;
      cnt_match             <= '0;
      cnt_miss              <= '0;
      cnt_orphan            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            state           <= S_EMIT;
            aso_tsrec_valid <= 1'b1;
            if (do_match) begin
              aso_tsrec_fingerprint <= head;
              aso_tsrec_timestamp   <= pend_ts;
              aso_tsrec_status      <= ST_MATCH;
              cnt_match             <= sat_inc(cnt_match);
            end else if (do_orphan) begin
              aso_tsrec_fingerprint <= pend_fp;
              aso_tsrec_timestamp   <= pend_ts;
              aso_tsrec_status      <= ST_ORPHAN;
              cnt_orphan            <= sat_inc(cnt_orphan);
            end else begin
              aso_tsrec_fingerprint <= head;
              aso_tsrec_timestamp   <= '0;
              aso_tsrec_status      <= ST_MISSED;
              cnt_miss              <= sat_inc(cnt_miss);
            end
          end
        end
        S_EMIT: begin
          if (aso_tsrec_ready) begin
            state           <= S_IDLE;
            aso_tsrec_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_tstamp_matcher.sv
// tb/tb_eth_tx_tstamp_matcher.sv - directed self-checking bench for eth_tx_tstamp_matcher
module tb_eth_tx_tstamp_matcher;
  localparam int TSW = 96;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            asi_fingerprint_valid = 1'b0;
  logic [7:0]      asi_fingerprint = '0;
  logic            asi_fingerprint_ready;
  logic            tstamp_valid = 1'b0;
  logic [TSW-1:0]  tstamp_data = '0;
  logic [7:0]      tstamp_fingerprint = '0;
  logic            aso_tsrec_valid;
  logic            aso_tsrec_ready = 1'b0;
  logic [7:0]      aso_tsrec_fingerprint;
  logic [TSW-1:0]  aso_tsrec_timestamp;
  logic [1:0]      aso_tsrec_status;
  logic [4:0]      fifo_level;
  logic [15:0]     cnt_match, cnt_miss, cnt_orphan, cnt_overflow;

  int checks = 0;
  int errors = 0;
  int n;

  eth_tx_tstamp_matcher #(
    .FIFO_DEPTH(16), .TS_WIDTH(TSW), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .asi_fingerprint_valid(asi_fingerprint_valid), .asi_fingerprint(asi_fingerprint),
    .asi_fingerprint_ready(asi_fingerprint_ready),
    .tstamp_valid(tstamp_valid), .tstamp_data(tstamp_data), .tstamp_fingerprint(tstamp_fingerprint),
    .aso_tsrec_valid(aso_tsrec_valid), .aso_tsrec_ready(aso_tsrec_ready),
    .aso_tsrec_fingerprint(aso_tsrec_fingerprint), .aso_tsrec_timestamp(aso_tsrec_timestamp),
    .aso_tsrec_status(aso_tsrec_status), .fifo_level(fifo_level),
    .cnt_match(cnt_match), .cnt_miss(cnt_miss), .cnt_orphan(cnt_orphan), .cnt_overflow(cnt_overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    asi_fingerprint_valid = 1'b0;
    tstamp_valid = 1'b0;
    aso_tsrec_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] fp);
    @(negedge clock);
    asi_fingerprint_valid = 1'b1;
    asi_fingerprint = fp;
    @(posedge clock);
    #1 asi_fingerprint_valid = 1'b0;
  endtask

  task automatic send_ts(input logic [7:0] fp, input logic [TSW-1:0] ts);
    @(negedge clock);
    tstamp_valid = 1'b1;
    tstamp_fingerprint = fp;
    tstamp_data = ts;
    @(posedge clock);
    #1 tstamp_valid = 1'b0;
  endtask

  // Counts negedges until a record appears, bounded
  task automatic wait_rec(output int cyc);
    cyc = 0;
    while (!aso_tsrec_valid && cyc < 60) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic expect_rec(input string tag, input logic [7:0] fp, input logic [TSW-1:0] ts,
                            input logic [1:0] st);
    int c;
    wait_rec(c);
    chk({tag, "_valid"}, aso_tsrec_valid, 1'b1);
    chk({tag, "_fp"}, aso_tsrec_fingerprint, fp);
    chk({tag, "_ts"}, aso_tsrec_timestamp, ts);
    chk({tag, "_status"}, aso_tsrec_status, st);
    aso_tsrec_ready = 1'b1;
    @(posedge clock);
    #1 aso_tsrec_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    // reset state
    chk("rst_valid", aso_tsrec_valid, 0);
    chk("rst_fp", aso_tsrec_fingerprint, 0);
    chk("rst_ts", aso_tsrec_timestamp, 0);
    chk("rst_status", aso_tsrec_status, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", asi_fingerprint_ready, 1);
    chk("rst_cnts", {cnt_match, cnt_miss, cnt_orphan, cnt_overflow}, 0);

    // single match, record two edges after the timestamp
    push(8'hA5);
    chk("m_level1", fifo_level, 1);
    send_ts(8'hA5, 96'h1234);
    wait_rec(n);
    chk("m_latency", n, 2);
    expect_rec("m", 8'hA5, 96'h1234, 2'd0);
    chk("m_cnt_match", cnt_match, 1);
    chk("m_level0", fifo_level, 0);

    // dropped fingerprint: MISSED then MATCH
    do_reset();
    push(8'hA5);
    push(8'h4A);
    send_ts(8'h4A, 96'h5678);
    expect_rec("mm_miss", 8'hA5, 96'h0, 2'd1);
    expect_rec("mm_match", 8'h4A, 96'h5678, 2'd0);
    chk("mm_cnt_miss", cnt_miss, 1);
    chk("mm_cnt_match", cnt_match, 1);
    chk("mm_level", fifo_level, 0);

    // timeout after 8 idle cycles
    do_reset();
    push(8'hA5);
    wait_rec(n);
    chk("to_latency", n, 9);
    expect_rec("to", 8'hA5, 96'h0, 2'd1);
    chk("to_level", fifo_level, 0);
    chk("to_cnt_miss", cnt_miss, 1);

    // orphan
    do_reset();
    send_ts(8'h33, 96'hABC);
    expect_rec("or", 8'h33, 96'hABC, 2'd2);
    chk("or_cnt", cnt_orphan, 1);

    // back-to-back timestamps with sink stalled
    do_reset();
    @(negedge clock);
    tstamp_valid = 1'b1; tstamp_fingerprint = 8'h11; tstamp_data = 96'h1;
    @(posedge clock);
    #1 tstamp_fingerprint = 8'h22; tstamp_data = 96'h2;
    @(posedge clock);
    #1 tstamp_fingerprint = 8'h33; tstamp_data = 96'h3;
    @(posedge clock);
    #1 tstamp_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("bb_hold_valid", aso_tsrec_valid, 1);
    chk("bb_hold_fp", aso_tsrec_fingerprint, 8'h11);
    chk("bb_hold_ts", aso_tsrec_timestamp, 96'h1);
    chk("bb_overflow", cnt_overflow, 1);
    expect_rec("bb_r1", 8'h11, 96'h1, 2'd2);
    expect_rec("bb_r2", 8'h22, 96'h2, 2'd2);
    repeat (4) @(negedge clock);
    chk("bb_drained", aso_tsrec_valid, 0);
    chk("bb_cnt_orphan", cnt_orphan, 2);

    // FIFO full; an orphan record held in EMIT blocks any pop
    do_reset();
    send_ts(8'h77, 96'h99);
    wait_rec(n);
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("full_level", fifo_level, 16);
    chk("full_ready", asi_fingerprint_ready, 0);
    @(negedge clock);
    asi_fingerprint_valid = 1'b1;
    asi_fingerprint = 8'h10;
    repeat (3) @(negedge clock);
    chk("full_held_level", fifo_level, 16);
    expect_rec("full_or", 8'h77, 96'h99, 2'd2);
    send_ts(8'h00, 96'h500);
    wait_rec(n);
    chk("full_match_fp", aso_tsrec_fingerprint, 8'h00);
    chk("full_match_ts", aso_tsrec_timestamp, 96'h500);
    repeat (2) @(negedge clock);
    chk("full_refill_level", fifo_level, 16);
    chk("full_cnt_match", cnt_match, 1);
    asi_fingerprint_valid = 1'b0;

    // reset while a record is held
    chk("rm_pre_valid", aso_tsrec_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rm_valid", aso_tsrec_valid, 0);
    chk("rm_level", fifo_level, 0);
    chk("rm_cnt_match", cnt_match, 0);
    chk("rm_ready", asi_fingerprint_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_tx_tstamp_matcher.md
# eth_tx_tstamp_matcher

Pairs each TX egress timestamp returned by the Ethernet MAC with the fingerprint the TX timestamp-request stage issued for that packet. It sits directly downstream of the request stage's fingerprint Avalon-ST output and beside the MAC's egress-timestamp return path. It emits one timestamp record per packet to the DMA/CSR side, and flags missed and orphan timestamps instead of silently mis-pairing them.

## Interface
- FIFO_DEPTH, 16: fingerprint FIFO entries; power of two, at least 2.
- TS_WIDTH, 96: egress timestamp width.
- TIMEOUT_CYCLES, 4096: idle cycles the FIFO head waits before it is declared missed; at least 1.
- CNT_WIDTH, 16: width of the statistics counters.
- clock  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- asi_fingerprint_valid  in  1  fingerprint from the request stage is valid.
- asi_fingerprint  in  8  fingerprint value.
- asi_fingerprint_ready  out  1  equals !fifo_full.
- tstamp_valid  in  1  MAC egress timestamp strobe; single cycle, no backpressure.
- tstamp_data  in  TS_WIDTH  egress timestamp.
- tstamp_fingerprint  in  8  fingerprint echoed by the MAC.
- aso_tsrec_valid  out  1  timestamp record is valid.
- aso_tsrec_ready  in  1  sink accepts the record.
- aso_tsrec_fingerprint  out  8  fingerprint carried by the record.
- aso_tsrec_timestamp  out  TS_WIDTH  timestamp carried by the record; 0 when the status is MISSED.
- aso_tsrec_status  out  2  0=MATCH, 1=MISSED, 2=ORPHAN; 3 is never driven.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- cnt_match, cnt_miss, cnt_orphan, cnt_overflow  out  CNT_WIDTH each  saturating event counters.

## Operation
- Fingerprint FIFO
  - A push occurs when asi_fingerprint_valid & asi_fingerprint_ready.
  - A pop occurs only when the FSM loads a MATCH or MISSED record.
  - A push and a pop in the same cycle leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Pending timestamp register (one entry: pend_valid, pend_ts, pend_fp)
  - Loaded on tstamp_valid when it is empty, or when it is being consumed in the same cycle.
  - Otherwise the incoming timestamp is dropped and cnt_overflow increments.
- FSM states: IDLE and EMIT. In IDLE, the first true condition below applies; each loads the output registers and moves to EMIT.
  1. pend_valid and FIFO not empty and head == pend_fp: record MATCH {head, pend_ts}. Pop the FIFO, clear pending, increment cnt_match.
  2. pend_valid and FIFO not empty and head != pend_fp: record MISSED {head, 0}. Pop the FIFO, keep pending so it is retried against the next head, increment cnt_miss.
  3. pend_valid and FIFO empty: record ORPHAN {pend_fp, pend_ts}. Clear pending, increment cnt_orphan.
  4. No pending, FIFO not empty, and timeout counter == TIMEOUT_CYCLES-1: record MISSED {head, 0}. Pop the FIFO, increment cnt_miss.
- EMIT: hold aso_tsrec_valid and all record fields stable until aso_tsrec_ready. The handshake returns the FSM to IDLE. No new record is loaded in the handshake cycle.
- Timeout counter
  - Increments each cycle the FSM is in IDLE with the FIFO not empty and no pending timestamp.
  - Clears on any pop, whenever the FIFO is empty, and whenever a timestamp is pending.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous assert): FSM in IDLE, FIFO empty, pending cleared, timeout counter 0.
  - Outputs: aso_tsrec_valid=0, record fields 0, fifo_level=0, all counters 0, asi_fingerprint_ready=1.
  - Deassertion is synchronous to clock.
- Timestamp latency: tstamp_valid sampled at edge E, then pend_valid=1 in cycle E+1, then aso_tsrec_valid=1 in cycle E+2, provided the FSM is in IDLE and the FIFO is not empty.
- A fingerprint pushed at edge E is visible as the FIFO head in cycle E+1.
- Record throughput is at most one record per 2 cycles (load, then handshake).
- FIFO full: asi_fingerprint_ready=0. The request stage's valid is sticky until accepted, so no fingerprint is lost.
- Reset mid-record: the record is discarded and aso_tsrec_valid drops immediately.

## Test plan
- Reset, then push fingerprint 0xA5, then tstamp_valid with fingerprint 0xA5 and ts 0x1234 -> after 2 cycles one MATCH record {0xA5, 0x1234}; cnt_match=1; fifo_level=0.
- Push 0xA5 then 0x4A, then a timestamp with fingerprint 0x4A -> MISSED {0xA5, 0} followed by MATCH {0x4A, ts}; cnt_miss=1, cnt_match=1.
- With TIMEOUT_CYCLES=8, push 0xA5 and send no timestamp -> MISSED {0xA5, 0} loaded after the 8th idle cycle; FIFO empty afterwards.
- FIFO empty, send a timestamp with fingerprint 0x33 -> ORPHAN {0x33, ts}; cnt_orphan=1.
- Hold aso_tsrec_ready=0 and send 3 back-to-back timestamps -> one record held stable, one pending, cnt_overflow=1; releasing ready drains records in order.
- Push 17 fingerprints with depth 16 -> ready=0 at fifo_level=16; the 17th fingerprint is accepted only after the first pop.
